seq_pattern_tx: RTL and testbench

SEQ_PATTERN_TX -- requirements
Module: seq_pattern_tx

---
 rtl/seq_pattern_tx.sv | 110 +++++++++++
 tb/tb_seq_pattern_tx.sv | 177 +++++++++++++++++
 2 files changed

// File: rtl/seq_pattern_tx.sv
// Serial pattern transmitter: shifts a loaded frame out MSB-first,
// optionally repeated with one idle gap cycle between repetitions.
module seq_pattern_tx #(
    parameter int MAXLEN = 8
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [MAXLEN-1:0] in_pattern,
    input  logic [3:0]        in_len,
    input  logic [1:0]        in_repeat,
    input  logic              abort,
    output logic              w,
    output logic              w_valid,
    output logic              busy,
    output logic              done
);

    localparam int LW = $clog2(MAXLEN + 1);

    typedef enum logic [1:0] {
        IDLE,
        SHIFT,
        GAP,
        DONE
    } state_t;

    state_t            state;
    logic [MAXLEN-1:0] pat_q;
    logic [MAXLEN-1:0] sh_q;
    logic [LW-1:0]     len_q;
    logic [LW-1:0]     idx_q;
    logic [1:0]        rep_q;
    logic [LW-1:0]     eff_len;
    logic [MAXLEN-1:0] aligned;
    logic              last;

    // Frame is left-aligned so the first bit always sits at the MSB.
    always_comb begin
        eff_len = LW'(MAXLEN);
        if (in_len != 4'd0 && 32'(in_len) <= MAXLEN)
            eff_len = LW'(in_len);
        aligned = in_pattern << (LW'(MAXLEN) - eff_len);
    end

    assign last = (idx_q == len_q - LW'(1));

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
            pat_q <= '0;
            sh_q  <= '0;
            len_q <= '0;
            idx_q <= '0;
            rep_q <= '0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (in_valid) begin
                        pat_q <= aligned;
                        sh_q  <= aligned;
                        len_q <= eff_len;
                        rep_q <= in_repeat;
                        idx_q <= '0;
                        state <= SHIFT;
                    end
                end
                SHIFT: begin
                    if (abort) begin
                        idx_q <= '0;
                        rep_q <= '0;
                        state <= IDLE;
                    end else if (last) begin
                        idx_q <= '0;
                        if (rep_q == 2'd0) begin
                            state <= DONE;
                        end else begin
                            rep_q <= rep_q - 2'd1;
                            state <= GAP;
                        end
                    end else begin
                        idx_q <= idx_q + LW'(1);
                        sh_q  <= sh_q << 1;
                    end
                end
                GAP: begin
                    if (abort) begin
                        rep_q <= '0;
                        state <= IDLE;
                    end else begin
                        sh_q  <= pat_q;
                        state <= SHIFT;
                    end
                end
                DONE: begin
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign in_ready = (state == IDLE);
    assign busy     = (state != IDLE);
    assign done     = (state == DONE);
    assign w_valid  = (state == SHIFT);
    assign w        = w_valid & sh_q[MAXLEN-1];

endmodule

// File: tb/tb_seq_pattern_tx.sv
// Directed scoreboard bench for seq_pattern_tx: per-cycle expected
// output vectors {w, w_valid, busy, done, in_ready} queued and popped.
module tb_seq_pattern_tx;

    logic       clk;
    logic       reset;
    logic       in_valid;
    logic       in_ready;
    logic [7:0] in_pattern;
    logic [3:0] in_len;
    logic [1:0] in_repeat;
    logic       abort;
    logic       w;
    logic       w_valid;
    logic       busy;
    logic       done;

    localparam logic [4:0] V_IDLE = 5'b00001;
    localparam logic [4:0] V_GAP  = 5'b00100;
    localparam logic [4:0] V_DONE = 5'b00110;

    logic [4:0] q[$];
    int vecs;
    int errs;
    int ones;
    logic z;

    seq_pattern_tx #(.MAXLEN(8)) dut (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_pattern(in_pattern),
        .in_len    (in_len),
        .in_repeat (in_repeat),
        .abort     (abort),
        .w         (w),
        .w_valid   (w_valid),
        .busy      (busy),
        .done      (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Bench-side detector: z once four consecutive 1s have been seen on w.
    always @(posedge clk) begin
        if (reset)
            ones <= 0;
        else if (w_valid)
            ones <= w ? ((ones >= 7) ? 7 : ones + 1) : 0;
    end
    assign z = (ones >= 4);

    task automatic chk(input logic [4:0] exp, input string tag);
        logic [4:0] obs;
        obs = {w, w_valid, busy, done, in_ready};
        vecs++;
        assert (obs === exp) else begin
            errs++;
            $error("FAIL %s obs=%b exp=%b", tag, obs, exp);
        end
    endtask

    // kill>0: abort (or reset if use_reset) during post-accept cycle kill.
    // hold: keep in_valid high with a different frame through DONE,
    // and pulse abort in the DONE cycle.
    task automatic run(input logic [7:0] pat, input logic [3:0] len,
                       input logic [1:0] rep, input int kill,
                       input bit use_reset, input bit hold,
                       input string tag);
        int L;
        int n;
        logic [4:0] e;
        L = (len == 4'd0 || len > 4'd8) ? 8 : int'(len);
        for (int r = 0; r <= int'(rep); r++) begin
            for (int i = 0; i < L; i++)
                q.push_back({pat[L-1-i], 4'b1100});
            if (r < int'(rep))
                q.push_back(V_GAP);
        end
        q.push_back(V_DONE);
        q.push_back(V_IDLE);
        if (kill > 0) begin
            while (q.size() > kill)
                void'(q.pop_back());
            q.push_back(V_IDLE);
        end
        in_pattern = pat;
        in_len     = len;
        in_repeat  = rep;
        in_valid   = 1'b1;
        @(posedge clk);
        #1;
        abort = 1'b0;
        if (hold) begin
            in_pattern = ~pat;
            in_len     = 4'd1;
            in_repeat  = 2'd0;
        end else begin
            in_valid = 1'b0;
        end
        n = 0;
        while (q.size() > 0) begin
            e = q.pop_front();
            n++;
            chk(e, tag);
            if (e == V_IDLE)
                in_valid = 1'b0;
            if (q.size() > 0) begin
                if (n == kill) begin
                    if (use_reset) reset = 1'b1;
                    else abort = 1'b1;
                end
                if (hold && e == V_DONE)
                    abort = 1'b1;
                @(posedge clk);
                #1;
                abort = 1'b0;
                reset = 1'b0;
            end
        end
    endtask

    initial begin
        vecs       = 0;
        errs       = 0;
        reset      = 1'b1;
        in_valid   = 1'b1;
        abort      = 1'b1;
        in_pattern = 8'hFF;
        in_len     = 4'd4;
        in_repeat  = 2'd3;
        for (int k = 0; k < 2; k++) begin
            @(posedge clk);
            #1;
            q.push_back(V_IDLE);
            chk(q.pop_front(), "reset");
        end
        reset    = 1'b0;
        in_valid = 1'b0;
        abort    = 1'b0;

        run(8'b0000_1101, 4'd4, 2'd0, 0, 0, 0, "basic");
        vecs++;
        assert (z === 1'b0) else begin
            errs++;
            $error("FAIL det_idle obs=%b exp=0", z);
        end
        run(8'b0000_1111, 4'd4, 2'd0, 0, 0, 0, "loopback");
        vecs++;
        assert (z === 1'b1) else begin
            errs++;
            $error("FAIL det_z obs=%b exp=1", z);
        end
        run(8'b0000_0011, 4'd2, 2'd2, 0, 0, 0, "repeat");
        run(8'hA5, 4'd0, 2'd0, 0, 0, 0, "len0");
        run(8'hA5, 4'd9, 2'd0, 0, 0, 0, "len9");
        run(8'h01, 4'd1, 2'd1, 0, 0, 0, "len1");
        run(8'hC3, 4'd8, 2'd0, 3, 0, 0, "abort");
        run(8'b0000_0010, 4'd2, 2'd3, 3, 1, 0, "rst_gap");
        run(8'b0000_1101, 4'd4, 2'd0, 0, 0, 0, "after_rst");
        run(8'h96, 4'd8, 2'd1, 0, 0, 1, "hold");
        abort = 1'b1;
        run(8'h5A, 4'd7, 2'd0, 0, 0, 0, "abort_load");

        $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout vecs=%0d", vecs);
        $fatal(1, "timeout");
    end

endmodule
